// File: rtl/req_debounce_latch8_if.sv
// Request/encoder-side bundle for req_debounce_latch8.
// The master side drives the raw requests and controls.
// The slave side, which is the debounce/latch block, drives the encoder-facing outputs.
interface req_debounce_latch8_if;
   logic [7:0] iReq;
   logic [7:0] iMask;
   logic       iEn;
   logic       iAck;
   logic [2:0] iAckIdx;
   logic       iOvfClr;
   logic [7:0] oData;
   logic       oEI;
   logic       oPend;
   logic [7:0] oOvf;

   modport master (
      output iReq, iMask, iEn, iAck, iAckIdx, iOvfClr,
      input  oData, oEI, oPend, oOvf
   );

   modport slave (
      input  iReq, iMask, iEn, iAck, iAckIdx, iOvfClr,
      output oData, oEI, oPend, oOvf
   );
endinterface

// File: rtl/req_debounce_latch8.sv
// req_debounce_latch8: upstream stage of the 8-to-3 active-low priority encoder.
// Each of the eight raw requests goes through a 2-flop synchroniser and then a
// per-channel debounce counter. Each debounced rising edge is latched as a
// sticky pending bit.
// oData drives the encoder iData input: it is the masked pending vector,
// active-low. oEI drives the encoder enable: it is iEn, registered and inverted.
// Pending bits are cleared by an indexed acknowledge.
// Optional macro REQ_DB_OVF_EN builds per-channel sticky overflow flags. A flag
// is set when a channel rises again while its pending bit is still set. Without
// the macro, oOvf is held at zero and iOvfClr has no effect.
// DB_CYCLES must be in 2..15, and 2**CNT_W must be greater than DB_CYCLES.
module req_debounce_latch8 #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 4
) (
   input logic             iClk,
   input logic             iRst,
   req_debounce_latch8_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [7:0]       sync1;
   logic [7:0]       sync2;
   logic [7:0]       stable;
   logic [7:0]       stable_nxt;
   logic [CNT_W-1:0] cnt     [8];
   logic [CNT_W-1:0] cnt_nxt [8];
   logic [7:0]       rise;
   logic [7:0]       ack_hit;
   logic [7:0]       pending;
   logic [7:0]       pending_nxt;
   logic [7:0]       visible;
   logic             en_q;

   // Debounce: count consecutive disagreeing cycles. Flip on the last one.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         stable_nxt[i] = stable[i];
         cnt_nxt[i]    = '0;
         if (sync2[i] != stable[i]) begin
            if (cnt[i] == CNT_LAST) begin
               stable_nxt[i] = sync2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   // Rise events, acknowledge decode and pending next state (a new rise beats an ack).
   always_comb begin
      rise        = stable_nxt & ~stable;
      ack_hit     = bus.iAck ? (8'b1 << bus.iAckIdx) : 8'h00;
      pending_nxt = rise | (pending & ~ack_hit);
   end

   // Synchroniser, debounce state, pending and enable registers.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         sync1   <= '0;
         sync2   <= '0;
         stable  <= '0;
         pending <= '0;
         en_q    <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1   <= bus.iReq;
         sync2   <= sync1;
         stable  <= stable_nxt;
         pending <= pending_nxt;
         en_q    <= bus.iEn;
         for (int i = 0; i < 8; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

`ifdef REQ_DB_OVF_EN
   logic [7:0] ovf;
   logic [7:0] ovf_set;

   // Overflow: a rise on a channel still pending that is not acked this cycle.
   always_comb begin
      ovf_set = rise & pending & ~ack_hit;
   end

   // Sticky overflow flags. A coincident new overflow wins over the clear.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         ovf <= '0;
      end else begin
         ovf <= ovf_set | (bus.iOvfClr ? 8'h00 : ovf);
      end
   end

   assign bus.oOvf = ovf;
`else
   assign bus.oOvf = 8'h00;
`endif

   // Encoder-facing outputs: combinational from pending and the mask only.
   always_comb begin
      visible   = pending & ~bus.iMask;
      bus.oData = ~visible;
      bus.oPend = |visible;
      bus.oEI   = ~en_q;
   end

endmodule

// File: doc/req_debounce_latch8.md
Name: req_debounce_latch8

Overview:
- Upstream stage of the 8-to-3 active-low priority encoder (encoder83_Pri).
- Synchronises and debounces eight raw request lines, then latches each rising edge as a sticky pending bit.
- Presents the masked pending vector active-low on oData, to drive the encoder's iData directly, and drives the encoder's active-low enable on oEI.
- Pending bits clear on an indexed acknowledge; the index comes from the encoder's 3-bit code.

Parameters:
- DB_CYCLES, 4: consecutive cycles a synchronised input must differ from its debounced state before that state flips. Legal range 2..15.
- CNT_W, 4: width of each per-channel debounce counter. Must satisfy 2**CNT_W > DB_CYCLES.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iReq  input  8  raw active-high requests, asynchronous to iClk.
- iMask  input  8  1 = channel masked from oData; its pending bit is still kept.
- iEn  input  1  1 = enable downstream encoder.
- iAck  input  1  1-cycle pulse, clears pending[iAckIdx].
- iAckIdx  input  3  channel index to clear.
- iOvfClr  input  1  clears all overflow flags.
- oData  output  8  active-low masked pending vector: ~(pending & ~iMask).
- oEI  output  1  active-low encoder enable, registered: ~iEn delayed one cycle.
- oPend  output  1  1 when any unmasked pending bit is set.
- oOvf  output  8  sticky per-channel overflow flags.

Behaviour:
- Reset: evaluated on the clock edge while iRst=1, and takes priority over every other event. All of the following clear to 0: sync stages, debounced state, counters, pending, ovf, and the oEI source register.
  - Outputs after reset: oData=8'hFF, oEI=1, oPend=0, oOvf=0.
  - Reset mid-debounce or with bits pending discards everything; no edge is generated on exit.
- Synchroniser: two flops per channel, s1<=iReq, s2<=s1.
- Debounce, per channel i:
  - s2[i]==stable[i]: cnt<=0.
  - s2[i]!=stable[i] and cnt<DB_CYCLES-1: cnt<=cnt+1.
  - s2[i]!=stable[i] and cnt==DB_CYCLES-1: stable[i]<=s2[i], cnt<=0.
  - A single-cycle return to equality restarts the count.
- Event detection: rise[i] is asserted in the cycle the debounce update flips stable[i] from 0 to 1. Falling flips produce no event.
- Pending update, per channel on each edge:
  - rise[i]=1: pending[i]<=1. This applies even if iAck targets i in the same cycle; the new event wins.
  - Else iAck=1 and iAckIdx==i: pending[i]<=0.
  - Ack of an already-clear bit: no effect.
  - iMask does not block setting pending.
- Overflow, per channel:
  - rise[i]=1 while pending[i] is already 1 and not cleared in that cycle: ovf[i]<=1.
  - iOvfClr=1: all ovf<=0. A coincident new overflow wins on that bit.
- Latency, DB_CYCLES=4, iReq rising just before edge 1 and held:
  - s2 high after edge 2.
  - Counter increments on edges 3, 4, 5; stable and pending set on edge 6.
  - oData bit low after edge 6. In general: DB_CYCLES+2 edges.
- oData and oPend are combinational from the pending register and iMask; no other input feeds them.
- oEI is registered and does not depend on pending.

Optional Feature:
- Macro REQ_DB_OVF_EN.
- Defined: overflow tracking exactly as above.
- Undefined: no ovf registers are built, oOvf is tied to 8'h00, and iOvfClr is ignored.

Test Plan:
- Reset release: iRst=1 for 2 cycles, then 0 with iReq=0. Required: oData=8'hFF, oEI=1, oPend=0, oOvf=0.
- Debounce latency, DB_CYCLES=4: iReq=8'h04 held, iMask=0, iEn=1.
  - oData=8'hFB exactly after the 6th edge, and not before.
  - oPend=1 from the same cycle; oEI=0.
- Glitch rejection: pulse iReq[1] high for 3 cycles, then low.
  - oData stays 8'hFF and no counter reaches the flip.
  - Repeat with a 1-cycle dropout inside a 5-cycle high: still no event.
- Ack and simultaneity:
  - With bits 0 and 3 pending, iAck=1, iAckIdx=0: oData goes 8'hF6 -> 8'hF7.
  - Ack bit 3 on the same cycle its new rise completes: bit 3 stays pending.
- Mask: pending=8'h81, iMask=8'h01. Required: oData=8'h7F, oPend=1. Clearing iMask gives oData=8'h7E with no clock edge.
- Overflow, REQ_DB_OVF_EN defined: second debounced rise on ch5 with no ack in between.
  - oOvf=8'h20.
  - iOvfClr gives 8'h00.
  - Rebuilt without the macro: oOvf stays 8'h00.
